// File: rtl/cpu_ctrl_pkg.sv
// Shared types and default syscall service codes for the CPU control slice.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1,
        HALT  = 2'd2
    } sc_state_t;

    localparam logic [31:0] SC_HALT = 32'd10;
    localparam logic [31:0] SC_DISP = 32'd34;

endpackage

// File: rtl/go_sync.sv
// Go-button conditioning: 2-flop synchroniser, optional debounce, rising-edge pulse.
// Debounce is built only when SYSCALL_CTRL_DEBOUNCE_EN is defined.
module go_sync
`ifdef SYSCALL_CTRL_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    output logic go_pulse
);

    logic s1;
    logic s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= go;
            s2 <= s1;
        end
    end

`ifdef SYSCALL_CTRL_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic             stable;
    logic             stable_q;

    // Level is high once s2 has been seen high on CNT_MAX consecutive edges.
    assign stable = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            stable_q <= 1'b0;
        end else begin
            stable_q <= stable;
            if (!s2)
                cnt <= '0;
            else if (!stable)
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign go_pulse = stable & ~stable_q;
`else
    logic s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            s3 <= 1'b0;
        else
            s3 <= s2;
    end

    assign go_pulse = s2 & ~s3;
`endif

endmodule

// File: rtl/syscall_ctrl.sv
// PC-enable sequencer resolving syscalls into display / pause / halt.
// Define SYSCALL_CTRL_DEBOUNCE_EN to debounce the Go button.
module syscall_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter logic [31:0] HALT_CODE       = SC_HALT,
    parameter logic [31:0] DISP_CODE       = SC_DISP,
    parameter int          DEBOUNCE_CYCLES = 16
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        syscall,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    input  logic        go,
    output logic        pc_en,
    output logic        halted,
    output logic        paused,
    output logic [31:0] disp_data,
    output logic        disp_valid,
    output logic [31:0] instr_cnt,
    output logic [15:0] pause_cnt,
    output sc_state_t   dbg_state
);

    sc_state_t state;
    sc_state_t state_next;
    logic      go_pulse;
    logic      is_disp;

`ifdef SYSCALL_CTRL_DEBOUNCE_EN
    go_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_go_sync (
`else
    go_sync u_go_sync (
`endif
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .go_pulse (go_pulse)
    );

    always_comb begin
        state_next = state;
        pc_en      = 1'b0;
        is_disp    = 1'b0;
        case (state)
            RUN: begin
                if (!syscall) begin
                    pc_en = 1'b1;
                end else if (v0 == DISP_CODE) begin
                    pc_en   = 1'b1;
                    is_disp = 1'b1;
                end else if (v0 == HALT_CODE) begin
                    state_next = HALT;
                end else begin
                    state_next = PAUSE;
                end
            end
            // The stalled syscall is still on the decode bus, so only Go matters.
            PAUSE: begin
                pc_en = go_pulse;
                if (go_pulse)
                    state_next = RUN;
            end
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    // disp_valid is a one-cycle strobe with no back-pressure: disp_data is
    // stable whenever disp_valid is high, and the consumer must take it then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            halted     <= 1'b0;
            paused     <= 1'b0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
            instr_cnt  <= '0;
            pause_cnt  <= '0;
        end else begin
            state      <= state_next;
            halted     <= (state_next == HALT);
            paused     <= (state_next == PAUSE);
            disp_valid <= is_disp;
            if (is_disp)
                disp_data <= a0;
            if (pc_en)
                instr_cnt <= instr_cnt + 32'd1;
            if (state == RUN && state_next == PAUSE && pause_cnt != 16'hFFFF)
                pause_cnt <= pause_cnt + 16'd1;
        end
    end

    assign dbg_state = state;

endmodule

// File: doc/syscall_ctrl.md
# syscall_ctrl

Sequencer that owns the program-counter enable of the single-cycle MIPS datapath and resolves `syscall` instructions. It inspects the syscall service code ($v0) and argument ($a0) that the datapath places on the register-file read ports, then decides per syscall whether to display-and-continue, pause until the operator presses Go, or halt permanently. It also keeps retired-instruction and pause statistics for the board display. It sits between instruction decode and the PC register, replacing the purely combinational enable path.

## Interface
Parameters:
- `HALT_CODE`, 32'd10: $v0 value that halts the CPU.
- `DISP_CODE`, 32'd34: $v0 value that displays $a0 and continues.
- `DEBOUNCE_CYCLES`, 16: stable-high cycles required on Go; used only with `SYSCALL_CTRL_DEBOUNCE_EN`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `syscall`  in  1  decoded: current instruction is `syscall`.
- `v0`  in  32  register read port 1 data (register 2 while `syscall` is high).
- `a0`  in  32  register read port 2 data (register 4 while `syscall` is high).
- `go`  in  1  raw, asynchronous operator button.
- `pc_en`  out  1  PC/register-write enable; the instruction retires on a clock edge with `pc_en`=1.
- `halted`  out  1  high in HALT.
- `paused`  out  1  high in PAUSE.
- `disp_data`  out  32  last displayed $a0.
- `disp_valid`  out  1  one-cycle pulse after `disp_data` updates.
- `instr_cnt`  out  32  retired instructions; wraps modulo 2^32.
- `pause_cnt`  out  16  PAUSE entries; saturates at 16'hFFFF.

## Operation
- States: RUN, PAUSE, HALT. Reset state is RUN.
- RUN:
  - `syscall`=0: `pc_en`=1.
  - `syscall`=1 and `v0`==DISP_CODE: `pc_en`=1, `disp_data`<=`a0`, `disp_valid` pulses next cycle.
  - `syscall`=1 and `v0`==HALT_CODE: `pc_en`=0; go to HALT.
  - `syscall`=1 with any other `v0`: `pc_en`=0; go to PAUSE; `pause_cnt`+1 (saturating).
- PAUSE:
  - `pc_en` = `go_pulse`. `syscall`, `v0` and `a0` are ignored, because the same syscall is still presented.
  - On `go_pulse`, the syscall retires and the FSM returns to RUN.
- HALT: `pc_en`=0 and `go` is ignored. Only `rst_n` exits HALT.
- `go_pulse` is a single-cycle rising-edge pulse from the synchronised `go`. Pulses occurring in RUN or HALT are discarded, not queued.
- `pc_en` is combinational from the state and the inputs. All other outputs are registered.
- `instr_cnt` increments on every edge where `pc_en`=1.
- Reset values: state RUN, `pc_en` follows RUN logic, `halted`=0, `paused`=0, `disp_data`=0, `disp_valid`=0, `instr_cnt`=0, `pause_cnt`=0, synchroniser flops 0.
- Reset asserted mid-PAUSE or mid-HALT returns to RUN immediately and clears the counters.

## Timing
- Synchroniser: s1 <= `go`, s2 <= s1, s3 <= s2; `go_pulse` = s2 & ~s3.
- Latency: `go` sampled high at edge n gives `go_pulse` high between edges n+1 and n+2. The PC advances at edge n+2.
- A syscall detected in RUN at edge m: `paused`/`halted` are high after edge m. The earliest possible resume edge is m+1.
- `disp_valid` is high for exactly the cycle after the retiring edge.
- Back-to-back DISP syscalls update `disp_data` on consecutive edges, with `disp_valid` high continuously.

## Configuration
- `SYSCALL_CTRL_DEBOUNCE_EN` defined:
  - s2 must be high for `DEBOUNCE_CYCLES` consecutive cycles before the debounced level rises.
  - `go_pulse` is the rising edge of the debounced level.
  - Any low sample of s2 clears the counter.
  - Latency is `DEBOUNCE_CYCLES` cycles beyond the figure in Timing.
- Macro undefined: no debounce counter exists, and `go_pulse` is exactly s2 & ~s3.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - state enum `sc_state_t` (RUN, PAUSE, HALT);
  - default syscall code constants `SC_HALT`=10 and `SC_DISP`=34.
- Sub-module `go_sync`: holds the 2-flop synchroniser, the optional debounce counter and the edge detector, and outputs `go_pulse`.

## Test plan
- Reset, then 5 cycles with `syscall`=0 -> `pc_en`=1 every cycle, `instr_cnt`=5, `halted`=`paused`=0.
- `syscall`=1, `v0`=34, `a0`=32'hDEADBEEF for one cycle -> `pc_en`=1, `disp_data`=32'hDEADBEEF, one `disp_valid` pulse, state stays RUN.
- `syscall`=1, `v0`=5 held -> `pc_en`=0, `paused`=1, `pause_cnt`=1. Raise `go` at edge n -> `pc_en`=1 only in cycle n+1..n+2, then back in RUN, `instr_cnt`+1.
- `syscall`=1, `v0`=10 -> `halted`=1, `pc_en`=0. Toggle `go` 3 times -> no change. Pulse `rst_n` low -> state RUN and all counters 0.
- `go` pulsed in RUN, then a PAUSE syscall -> stays paused until a new `go` edge. Reset asserted mid-PAUSE -> `paused`=0 asynchronously.
- With `SYSCALL_CTRL_DEBOUNCE_EN` and `DEBOUNCE_CYCLES`=16: `go` high for 10 cycles -> no resume; `go` high for 20 cycles -> exactly one resume.
